tb_wr_memory: RTL and testbench
===============================

TB_WR_MEMORY -- requirements
Module: tb_wr_memory

Interface
REQ-001 SHALL have parameter DataWidth, default 32, width of the captured data word.
REQ-002 SHALL have parameter AddrWidth, default 32, width of all address and count ports.
REQ-003 SHALL have parameter MemDepth, default 1024, number of capture words.
REQ-004 SHALL have port clk_i  input  1  clock, rising edge.
REQ-005 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en_i  input  1  capture enable; low forces IDLE.
REQ-007 SHALL have port target_cnt_i  input  AddrWidth  number of beats to capture; 0 means "until full".
REQ-008 SHALL have port stall_every_i  input  AddrWidth  backpressure period in accepted beats; 0 disables.
REQ-009 SHALL have port stall_len_i  input  AddrWidth  ready-low cycles per stall; 0 is treated as 1.
REQ-010 SHALL have port wr_acc_data_i  input  DataWidth  accelerator output data.
REQ-011 SHALL have port wr_acc_valid_i  input  1  accelerator data valid.
REQ-012 SHALL have port wr_acc_ready_o  output  1  capture ready.
REQ-013 SHALL have port wr_acc_addr_o  output  AddrWidth  next capture address.
REQ-014 SHALL have port rd_addr_i  input  AddrWidth  testbench readback address.
REQ-015 SHALL have port rd_data_o  output  DataWidth  combinational readback data, mem[rd_addr_i].
REQ-016 SHALL have port wr_cnt_o  output  AddrWidth  accepted-beat count.
REQ-017 SHALL have port full_o  output  1  last memory word written.
REQ-018 SHALL have port done_o  output  1  capture complete (target reached or full).

Function
REQ-019 SHALL implement FSM states IDLE, CAPTURE, STALL, DONE.
REQ-020 SHALL move IDLE->CAPTURE on the first cycle en_i=1.
REQ-021 SHALL drive wr_acc_ready_o=1 only in CAPTURE, decoded combinationally from registered state.
REQ-022 SHALL accept a beat when valid && ready: mem[addr]<=data, addr+1, wr_cnt+1, same edge.
REQ-023 SHALL not require valid to be held; valid without ready changes nothing.
REQ-024 SHALL move CAPTURE->DONE on the accepting edge where wr_cnt+1 == target_cnt_i (target_cnt_i != 0).
REQ-025 SHALL move CAPTURE->DONE and set full_o on the accepting edge writing address MemDepth-1; no wrap-around, no overwrite.
REQ-026 SHALL give full/target priority over stall when both trigger on one edge.
REQ-027 SHALL move CAPTURE->STALL when stall_every_i != 0 and (wr_cnt+1) mod stall_every_i == 0 on an accepting edge.
REQ-028 SHALL hold STALL for max(stall_len_i,1) cycles using an internal down-counter, then return to CAPTURE.
REQ-029 SHALL hold done_o=1 in DONE, ready=0, until en_i=0.
REQ-030 SHALL, when en_i=0 in any state, go to IDLE next edge, clear addr, wr_cnt, full_o, done_o, stall counter; memory contents retained.
REQ-031 SHALL sample target_cnt_i/stall_* every cycle (static during capture by usage rule).

Reset
REQ-032 SHALL on rst_ni=0 clear state=IDLE, addr=0, wr_cnt=0, full_o=0, done_o=0, stall counter=0, all mem words=0.
REQ-033 SHALL drive wr_acc_ready_o=0 during and immediately after reset; reset mid-capture discards all progress.

Structure
REQ-034 SHALL place the FSM state enum (IDLE, CAPTURE, STALL, DONE) in the shared testbench package tb_mem_pkg.
REQ-035 SHALL be a single module with no sub-modules; counters inline.

Verification
REQ-036 SHALL test: target=4, stall off, valid=1 constant, data 0xA0..0xA3 -> 4 beats in 4 cycles, mem[0..3]=0xA0..0xA3, done_o next cycle, ready=0.
REQ-037 SHALL test: stall_every=2, stall_len=3, target=6 -> ready pattern 1,1,0,0,0,1,1,0,0,0,1,1, wr_cnt=6.
REQ-038 SHALL test: MemDepth=8, target=0, continuous valid -> 8 beats, full_o=1, done_o=1, 9th beat not accepted, mem[0] unchanged.
REQ-039 SHALL test: valid toggling 1,0,1,0, target=2 -> writes only on valid cycles, wr_acc_addr_o 0->1->2.
REQ-040 SHALL test: en_i dropped after 3 beats, re-raised -> addr/wr_cnt restart at 0, mem[0..2] retained until overwritten.
REQ-041 SHALL test: rst_ni pulsed mid-STALL -> all outputs 0, mem cleared, IDLE on release.

Source files
------------

// File: rtl/tb_mem_pkg.sv
// Shared types for the capture memory used by accelerator testbenches.
package tb_mem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        STALL,
        DONE
    } state_e;

    // Stall counter preload: a length of 0 behaves like 1.
    function automatic logic [31:0] stall_preload(input logic [31:0] len);
        return (len == '0) ? '0 : len - 32'd1;
    endfunction

endpackage

// File: rtl/tb_wr_memory.sv
// Capture memory for accelerator write data with a programmable
// beat target and periodic ready backpressure.
module tb_wr_memory
    import tb_mem_pkg::*;
#(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int MemDepth  = 1024
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 en_i,
    input  logic [AddrWidth-1:0] target_cnt_i,
    input  logic [AddrWidth-1:0] stall_every_i,
    input  logic [AddrWidth-1:0] stall_len_i,
    input  logic [DataWidth-1:0] wr_acc_data_i,
    input  logic                 wr_acc_valid_i,
    output logic                 wr_acc_ready_o,
    output logic [AddrWidth-1:0] wr_acc_addr_o,
    input  logic [AddrWidth-1:0] rd_addr_i,
    output logic [DataWidth-1:0] rd_data_o,
    output logic [AddrWidth-1:0] wr_cnt_o,
    output logic                 full_o,
    output logic                 done_o
);

    localparam int IdxW = (MemDepth > 1) ? $clog2(MemDepth) : 1;
    localparam logic [AddrWidth-1:0] LastAddr = AddrWidth'(MemDepth - 1);
    localparam logic [AddrWidth-1:0] Depth    = AddrWidth'(MemDepth);
    localparam logic [AddrWidth-1:0] One      = AddrWidth'(1);

    state_e state;

    logic [DataWidth-1:0] mem [MemDepth];

    logic [AddrWidth-1:0] addr;
    logic [AddrWidth-1:0] wr_cnt;
    logic [AddrWidth-1:0] stall_cnt;
    logic [AddrWidth-1:0] period_cnt;
    logic                 full;
    logic                 done;

    logic                 accept;
    logic                 hit_target;
    logic                 hit_full;
    logic                 hit_stall;
    logic [AddrWidth-1:0] cnt_next;
    logic [AddrWidth-1:0] period_next;
    logic [AddrWidth-1:0] stall_load;
    logic [31:0]          preload;

    assign wr_acc_ready_o = (state == CAPTURE);
    assign accept         = en_i && wr_acc_valid_i && wr_acc_ready_o;

    assign cnt_next    = wr_cnt + One;
    assign period_next = period_cnt + One;
    assign hit_target  = (target_cnt_i != '0) && (cnt_next == target_cnt_i);
    assign hit_full    = (addr == LastAddr);
    assign hit_stall   = (stall_every_i != '0) && (period_next == stall_every_i);

    // Stall lengths wider than 32 bits are clipped by the preload helper.
    assign preload    = stall_preload(32'(stall_len_i));
    assign stall_load = AddrWidth'(preload);

    assign wr_acc_addr_o = addr;
    assign wr_cnt_o      = wr_cnt;
    assign full_o        = full;
    assign done_o        = done;

    assign rd_data_o = (rd_addr_i < Depth) ? mem[rd_addr_i[IdxW-1:0]] : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < MemDepth; i++) begin
                mem[i] <= '0;
            end
        end else if (accept) begin
            mem[addr[IdxW-1:0]] <= wr_acc_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            addr       <= '0;
            wr_cnt     <= '0;
            stall_cnt  <= '0;
            period_cnt <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else if (!en_i) begin
            state      <= IDLE;
            addr       <= '0;
            wr_cnt     <= '0;
            stall_cnt  <= '0;
            period_cnt <= '0;
            full       <= 1'b0;
            done       <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    if (accept) begin
                        addr       <= addr + One;
                        wr_cnt     <= cnt_next;
                        period_cnt <= period_next;
                        // Completion wins over a stall due on the same beat.
                        if (hit_full || hit_target) begin
                            state <= DONE;
                            done  <= 1'b1;
                            full  <= hit_full;
                        end else if (hit_stall) begin
                            state      <= STALL;
                            stall_cnt  <= stall_load;
                            period_cnt <= '0;
                        end
                    end
                end
                STALL: begin
                    if (stall_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        stall_cnt <= stall_cnt - One;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tb_wr_memory.sv
// Directed and randomized checks of the capture memory against
// expectations derived from its beat, stall and completion rules.
module tb_tb_wr_memory;

    localparam int DW = 32;
    localparam int AW = 16;
    localparam int MD = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [AW-1:0] target;
    logic [AW-1:0] every;
    logic [AW-1:0] len;
    logic [DW-1:0] data;
    logic          valid;
    logic          ready;
    logic [AW-1:0] addr;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic [AW-1:0] cnt;
    logic          full;
    logic          done;

    int total = 0;
    int bad   = 0;

    tb_wr_memory #(
        .DataWidth(DW),
        .AddrWidth(AW),
        .MemDepth (MD)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .en_i          (en),
        .target_cnt_i  (target),
        .stall_every_i (every),
        .stall_len_i   (len),
        .wr_acc_data_i (data),
        .wr_acc_valid_i(valid),
        .wr_acc_ready_o(ready),
        .wr_acc_addr_o (addr),
        .rd_addr_i     (rd_addr),
        .rd_data_o     (rd_data),
        .wr_cnt_o      (cnt),
        .full_o        (full),
        .done_o        (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_mem(input string tag, input int idx,
                           input logic [DW-1:0] exp);
        rd_addr = AW'(idx);
        #1;
        chk(tag, 64'(rd_data), 64'(exp));
    endtask

    task automatic setup(input int t, input int e, input int l);
        target = AW'(t);
        every  = AW'(e);
        len    = AW'(l);
    endtask

    logic [DW-1:0] mdl_mem [MD];
    logic          ready_pat [12];

    initial begin
        rst_n   = 1'b0;
        en      = 1'b0;
        valid   = 1'b0;
        data    = '0;
        rd_addr = '0;
        setup(0, 0, 0);
        repeat (3) tick();
        chk("rst_ready", 64'(ready), 0);
        chk("rst_addr", 64'(addr), 0);
        chk("rst_cnt", 64'(cnt), 0);
        chk("rst_done", 64'({full, done}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("idle_ready", 64'(ready), 0);

        // Four beats with constant valid.
        setup(4, 0, 0);
        en    = 1'b1;
        valid = 1'b1;
        data  = 32'hA0;
        tick();
        chk("t1_ready0", 64'(ready), 1);
        for (int i = 0; i < 4; i++) begin
            data = DW'(32'hA0 + i);
            chk("t1_ready", 64'(ready), 1);
            chk("t1_addr", 64'(addr), 64'(i));
            tick();
            chk("t1_cnt", 64'(cnt), 64'(i + 1));
        end
        chk("t1_done", 64'(done), 1);
        chk("t1_ready_end", 64'(ready), 0);
        chk("t1_full", 64'(full), 0);
        valid = 1'b0;
        for (int i = 0; i < 4; i++) chk_mem("t1_mem", i, DW'(32'hA0 + i));
        en = 1'b0;
        tick();
        chk("t1_clear", 64'({done, cnt, addr}), 0);

        // Periodic backpressure: every 2 beats, 3 cycles.
        ready_pat = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
        setup(6, 2, 3);
        en    = 1'b1;
        valid = 1'b1;
        tick();
        for (int i = 0; i < 12; i++) begin
            data = DW'(32'h50 + i);
            chk("t2_ready", 64'(ready), 64'(ready_pat[i]));
            tick();
        end
        chk("t2_cnt", 64'(cnt), 6);
        chk("t2_done", 64'(done), 1);
        en = 1'b0;
        tick();

        // Fill to the last word with no target.
        setup(0, 0, 0);
        en    = 1'b1;
        valid = 1'b1;
        tick();
        for (int i = 0; i < MD; i++) begin
            data = DW'(32'h100 + i);
            tick();
        end
        chk("t3_full", 64'(full), 1);
        chk("t3_done", 64'(done), 1);
        chk("t3_cnt", 64'(cnt), 64'(MD));
        data = 32'hDEAD;
        tick();
        chk("t3_cnt_hold", 64'(cnt), 64'(MD));
        chk_mem("t3_mem0", 0, 32'h100);
        chk_mem("t3_mem7", 7, 32'h107);
        valid = 1'b0;
        en    = 1'b0;
        tick();
        chk("t3_full_clr", 64'(full), 0);

        // Valid toggling with target 2.
        setup(2, 0, 0);
        en = 1'b1;
        tick();
        chk("t4_addr0", 64'(addr), 0);
        valid = 1'b1;
        data  = 32'hB0;
        tick();
        chk("t4_addr1", 64'(addr), 1);
        valid = 1'b0;
        data  = 32'hBB;
        tick();
        chk("t4_addr1_hold", 64'(addr), 1);
        valid = 1'b1;
        data  = 32'hB1;
        tick();
        chk("t4_addr2", 64'(addr), 2);
        chk("t4_done", 64'(done), 1);
        valid = 1'b0;
        tick();
        chk_mem("t4_mem0", 0, 32'hB0);
        chk_mem("t4_mem1", 1, 32'hB1);
        chk_mem("t4_mem2", 2, 32'h102);
        en = 1'b0;
        tick();

        // Enable dropped after three beats, then re-raised.
        setup(0, 0, 0);
        en = 1'b1;
        tick();
        valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            data = DW'(32'hC0 + i);
            tick();
        end
        valid = 1'b0;
        en    = 1'b0;
        tick();
        chk("t5_addr", 64'(addr), 0);
        chk("t5_cnt", 64'(cnt), 0);
        for (int i = 0; i < 3; i++) chk_mem("t5_mem", i, DW'(32'hC0 + i));
        en = 1'b1;
        tick();
        chk("t5_addr_re", 64'(addr), 0);
        valid = 1'b1;
        data  = 32'hD0;
        tick();
        valid = 1'b0;
        chk_mem("t5_mem0_new", 0, 32'hD0);
        chk_mem("t5_mem1_kept", 1, 32'hC1);
        en = 1'b0;
        tick();

        // Reset pulsed while stalled.
        setup(0, 1, 5);
        en = 1'b1;
        tick();
        valid = 1'b1;
        data  = 32'hE0;
        tick();
        valid = 1'b0;
        tick();
        chk("t6_stalled", 64'(ready), 0);
        chk("t6_cnt_pre", 64'(cnt), 1);
        chk_mem("t6_mem_pre", 0, 32'hE0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_outs", 64'({ready, full, done, cnt, addr}), 0);
        chk_mem("t6_mem0", 0, 0);
        chk_mem("t6_mem1", 1, 0);
        en = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("t6_idle", 64'(ready), 0);
        en = 1'b1;
        tick();
        chk("t6_capture", 64'(ready), 1);
        en = 1'b0;
        tick();

        // Randomized runs against a beat-level reference model.
        for (int r = 0; r < 8; r++) begin
            int t, e, l, eff, m_cnt, stall_left, cyc;
            bit m_done, exp_ready, acc;
            t   = $urandom_range(0, MD);
            e   = $urandom_range(0, 3);
            l   = $urandom_range(0, 3);
            eff = (t == 0) ? MD : t;
            setup(t, e, l);
            en = 1'b1;
            tick();
            m_cnt      = 0;
            stall_left = 0;
            m_done     = 1'b0;
            cyc        = 0;
            while (!m_done && cyc < 400) begin
                exp_ready = (stall_left == 0);
                valid = ($urandom_range(0, 9) < 7);
                data  = $urandom;
                acc   = valid && exp_ready;
                chk("rnd_ready", 64'(ready), 64'(exp_ready));
                if (acc) mdl_mem[m_cnt] = data;
                tick();
                cyc++;
                if (!exp_ready) stall_left--;
                if (acc) begin
                    m_cnt++;
                    if (m_cnt == eff) m_done = 1'b1;
                    else if (e != 0 && m_cnt % e == 0)
                        stall_left = (l == 0) ? 1 : l;
                end
            end
            if (!m_done) begin
                total++;
                bad++;
                $error("FAIL rnd_timeout: observed=%0d expected=%0d", m_cnt, eff);
            end
            valid = 1'b0;
            chk("rnd_done", 64'(done), 1);
            chk("rnd_ready_done", 64'(ready), 0);
            chk("rnd_cnt", 64'(cnt), 64'(m_cnt));
            chk("rnd_full", 64'(full), 64'(m_cnt == MD));
            for (int i = 0; i < m_cnt; i++) chk_mem("rnd_mem", i, mdl_mem[i]);
            en = 1'b0;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
